cp0_exception_unit: RTL and testbench

- Coprocessor-0 register file and exception responder for the 5-stage MIPS core.
- Consumes what the instruction decoder raises (cp0read/cp0write, excepttype, isindelayslot), plus memory-stage exception codes and external interrupts.
- Sits at the MEM/WB boundary.
- Returns CP0 read data, the pipeline flush request and the redirect PC.

---
 rtl/cp0_exception_unit_pkg.sv | 65 ++++++
 rtl/cp0_exception_unit_timer.sv | 49 ++++
 rtl/cp0_exception_unit.sv | 123 ++++++++++++
 tb/tb_cp0_exception_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception type encodings, ExcCodes
// and Status/Cause field positions. The instruction decoder emits the same code set.
package cp0_exception_unit_pkg;

    typedef enum logic [4:0] {
        CP0_BADVADDR = 5'd8,
        CP0_COUNT    = 5'd9,
        CP0_COMPARE  = 5'd11,
        CP0_STATUS   = 5'd12,
        CP0_CAUSE    = 5'd13,
        CP0_EPC      = 5'd14
    } cp0_reg_e;

    // Resolved exception types as carried down the pipeline (0 = none)
    localparam logic [31:0] ET_NONE = 32'h0;
    localparam logic [31:0] ET_INT  = 32'h1;
    localparam logic [31:0] ET_ADEL = 32'h4;
    localparam logic [31:0] ET_ADES = 32'h5;
    localparam logic [31:0] ET_SYS  = 32'h8;
    localparam logic [31:0] ET_BP   = 32'h9;
    localparam logic [31:0] ET_RI   = 32'hA;
    localparam logic [31:0] ET_OV   = 32'hC;
    localparam logic [31:0] ET_ERET = 32'hE;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC0_0380;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;

    // True for the synchronous exception types this unit responds to
    function automatic logic is_exception(input logic [31:0] et);
        case (et)
            ET_ADEL, ET_ADES, ET_SYS, ET_BP, ET_RI, ET_OV: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] exc_code(input logic [31:0] et);
        case (et)
            ET_ADEL: return EXC_ADEL;
            ET_ADES: return EXC_ADES;
            ET_SYS:  return EXC_SYS;
            ET_BP:   return EXC_BP;
            ET_RI:   return EXC_RI;
            ET_OV:   return EXC_OV;
            default: return EXC_INT;
        endcase
    endfunction

    function automatic logic is_addr_error(input logic [31:0] et);
        return (et == ET_ADEL) || (et == ET_ADES);
    endfunction

endpackage

// File: rtl/cp0_exception_unit_timer.sv
// CP0 Count/Compare pair: prescaled Count, Compare, and the sticky timer interrupt
// that only an MTC0 to Compare clears.
module cp0_exception_unit_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic presc;
    logic tick;

    assign tick = (COUNT_DIV == 1) ? 1'b1 : presc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
            presc <= 1'b0;
        end else if (count_we) begin
            count <= wdata;
            presc <= 1'b0;
        end else begin
            if (tick)
                count <= count + 32'd1;
            presc <= (COUNT_DIV == 1) ? 1'b0 : ~presc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare   <= 32'd0;
            timer_int <= 1'b0;
        end else if (compare_we) begin
            compare   <= wdata;
            timer_int <= 1'b0;
        end else if ((count == compare) && (compare != 32'd0)) begin
            timer_int <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 register file and exception responder at the MEM/WB boundary: detects
// interrupts, takes exceptions/ERET, and drives the flush and redirect PC.
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_vaddr_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o,
    output logic        flush_o,
    output logic [31:0] newpc_o
);

    logic [31:0] status, epc, badvaddr, count, compare;
    logic        cause_bd;
    logic [7:0]  cause_ip;
    logic [4:0]  cause_exccode;

    logic        int_req, exc_take, eret, wr;
    logic [4:0]  exccode;

    assign status_o    = status;
    assign epc_o       = epc;
    assign cause_o     = {cause_bd, 15'd0, cause_ip, 1'b0, cause_exccode, 2'b00};

    // An interrupt pre-empts whatever the MEM instruction raised; pc_i==0 marks a bubble
    assign int_req  = (|(cause_ip & status[15:8])) & status[STATUS_IE]
                    & ~status[STATUS_EXL] & (pc_i != 32'd0);
    assign exc_take = int_req | is_exception(excepttype_i);
    assign eret     = ~int_req & (excepttype_i == ET_ERET);
    assign exccode  = int_req ? EXC_INT : exc_code(excepttype_i);
    assign wr       = we_i & ~exc_take & ~eret;

    assign flush_o  = ~rst & (exc_take | eret);
    assign newpc_o  = exc_take ? EXC_VECTOR : epc;

    cp0_exception_unit_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr && (waddr_i == CP0_COUNT)),
        .compare_we (wr && (waddr_i == CP0_COMPARE)),
        .wdata      (wdata_i),
        .count      (count),
        .compare    (compare),
        .timer_int  (timer_int_o)
    );

    // NOTE: the default assignment ahead of the case keeps this block free of latches.
    always_comb begin
        rdata_o = 32'd0;
        case (raddr_i)
            CP0_BADVADDR: rdata_o = badvaddr;
            CP0_COUNT:    rdata_o = count;
            CP0_COMPARE:  rdata_o = compare;
            CP0_STATUS:   rdata_o = status;
            CP0_CAUSE:    rdata_o = cause_o;
            CP0_EPC:      rdata_o = epc;
            default:      rdata_o = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= STATUS_RESET;
        end else if (exc_take) begin
            status[STATUS_EXL] <= 1'b1;
        end else if (eret) begin
            status[STATUS_EXL] <= 1'b0;
        end else if (wr && (waddr_i == CP0_STATUS)) begin
            status <= (status & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
        end
    end

    // Hardware IP bits track the pins every cycle, even while an exception is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_bd      <= 1'b0;
            cause_ip      <= 8'd0;
            cause_exccode <= 5'd0;
        end else begin
            cause_ip[7:2] <= {int_i[5] | timer_int_o, int_i[4:0]};
            if (exc_take) begin
                cause_exccode <= exccode;
                if (!status[STATUS_EXL])
                    cause_bd <= in_delayslot_i;
            end else if (wr && (waddr_i == CP0_CAUSE)) begin
                cause_ip[1:0] <= wdata_i[9:8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc      <= 32'd0;
            badvaddr <= 32'd0;
        end else begin
            if (exc_take && !status[STATUS_EXL])
                epc <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
            else if (wr && (waddr_i == CP0_EPC))
                epc <= wdata_i;
            if (exc_take && !int_req && is_addr_error(excepttype_i))
                badvaddr <= bad_vaddr_i;
        end
    end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Self-checking bench for cp0_exception_unit: directed vector table, timer and
// reset sequences, then randomized traffic against a behavioural CP0 model.
module tb_cp0_exception_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] pc_i;
    logic        in_delayslot_i;
    logic [31:0] bad_vaddr_i;
    logic [31:0] status_o, cause_o, epc_o, newpc_o;
    logic        timer_int_o, flush_o;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    cp0_exception_unit #(
        .EXC_VECTOR (VEC),
        .COUNT_DIV  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .raddr_i        (raddr_i),
        .rdata_o        (rdata_o),
        .int_i          (int_i),
        .excepttype_i   (excepttype_i),
        .pc_i           (pc_i),
        .in_delayslot_i (in_delayslot_i),
        .bad_vaddr_i    (bad_vaddr_i),
        .status_o       (status_o),
        .cause_o        (cause_o),
        .epc_o          (epc_o),
        .timer_int_o    (timer_int_o),
        .flush_o        (flush_o),
        .newpc_o        (newpc_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [5:0]  intr;
        logic [31:0] et;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic        exp_flush;
        logic [31:0] exp_newpc;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic [4:0] raddr, input logic [5:0] intr, input logic [31:0] et,
                               input logic [31:0] pc, input logic ds, input logic [31:0] bad,
                               input logic fl, input logic [31:0] npc, input logic [31:0] rd);
        vec_t r;
        r.we = we; r.waddr = waddr; r.wdata = wdata; r.raddr = raddr; r.intr = intr;
        r.et = et; r.pc = pc; r.ds = ds; r.bad = bad;
        r.exp_flush = fl; r.exp_newpc = npc; r.exp_rdata = rd;
        return r;
    endfunction

    task automatic apply_idle();
        we_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0; raddr_i = 5'd0; int_i = 6'd0;
        excepttype_i = 32'd0; pc_i = 32'd0; in_delayslot_i = 1'b0; bad_vaddr_i = 32'd0;
    endtask

    task automatic apply_vec(input vec_t r);
        we_i = r.we; waddr_i = r.waddr; wdata_i = r.wdata; raddr_i = r.raddr; int_i = r.intr;
        excepttype_i = r.et; pc_i = r.pc; in_delayslot_i = r.ds; bad_vaddr_i = r.bad;
    endtask

    // Behavioural model: architectural register values plus cycles since the
    // Count prescaler was last cleared.
    logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
    logic        m_timer;
    int          m_since;

    task automatic model_reset();
        m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_badv = 0;
        m_count = 0; m_compare = 0; m_timer = 0; m_since = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_intreq();
        return (|(m_cause[15:8] & m_status[15:8])) && m_status[0] && !m_status[1] && (pc_i != 0);
    endfunction

    function automatic logic m_sync_exc();
        return excepttype_i inside {32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC};
    endfunction

    // Advance the model across one clock edge using the inputs currently applied
    task automatic model_edge();
        logic        irq, exc, eret, wr;
        logic [31:0] n_status, n_cause, n_epc, n_badv, n_count, n_compare;
        logic        n_timer;
        irq  = m_intreq();
        exc  = irq || m_sync_exc();
        eret = !irq && (excepttype_i == 32'hE);
        wr   = we_i && !exc && !eret;
        n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_badv = m_badv;
        n_count = m_count; n_compare = m_compare;

        n_timer = (wr && waddr_i == 5'd11) ? 1'b0
                : (m_timer || (m_count == m_compare && m_compare != 0));
        if (wr && waddr_i == 5'd11) n_compare = wdata_i;
        if (wr && waddr_i == 5'd9) begin
            n_count = wdata_i;
            m_since = 0;
        end else begin
            m_since++;
            if (m_since % 2 == 0) n_count = m_count + 1;
        end

        n_cause[15:10] = {int_i[5] | m_timer, int_i[4:0]};
        if (exc) begin
            n_status[1]   = 1'b1;
            n_cause[6:2]  = irq ? 5'd0 : excepttype_i[4:0];
            if (!m_status[1]) begin
                n_cause[31] = in_delayslot_i;
                n_epc       = in_delayslot_i ? pc_i - 4 : pc_i;
            end
            if (!irq && (excepttype_i == 4 || excepttype_i == 5)) n_badv = bad_vaddr_i;
        end else if (eret) begin
            n_status[1] = 1'b0;
        end else if (wr) begin
            if (waddr_i == 5'd12) n_status = (m_status & ~32'h0000_FF03) | (wdata_i & 32'h0000_FF03);
            if (waddr_i == 5'd13) n_cause[9:8] = wdata_i[9:8];
            if (waddr_i == 5'd14) n_epc = wdata_i;
        end

        m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_badv = n_badv;
        m_count = n_count; m_compare = n_compare; m_timer = n_timer;
    endtask

    logic [4:0] reg_pool [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};

    initial begin
        logic [31:0] c0;
        int          waited;
        logic        irq, exc, eret;

        rst = 1'b1;
        apply_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state and Count prescaling
        raddr_i = 5'd12;
        #1;
        check("reset_status", rdata_o, 32'h0040_0000);
        check("reset_epc", epc_o, 32'd0);
        check("reset_cause", cause_o, 32'd0);
        check("reset_timer", timer_int_o, 1'b0);
        check("reset_flush", flush_o, 1'b0);
        raddr_i = 5'd9;
        #1;
        c0 = rdata_o;
        check("reset_count", c0, 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check("count_rate", rdata_o, c0 + 32'd2);
        @(negedge clk);

        // Directed vector table, one row per cycle from this point
        vecs.push_back(v(0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000));
        vecs.push_back(v(0, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 14, 0, 32'h8, 32'hBFC0_0100, 1, 0, 1, VEC, 32'h0));
        vecs.push_back(v(0, 0, 0, 14, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_00FC));
        vecs.push_back(v(0, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0020));
        vecs.push_back(v(0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0002));
        vecs.push_back(v(0, 0, 0, 8, 0, 32'h4, 32'h1000, 0, 32'h8000_0003, 1, VEC, 32'h0));
        vecs.push_back(v(0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0003));
        vecs.push_back(v(0, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0010));
        vecs.push_back(v(0, 0, 0, 14, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_00FC));
        vecs.push_back(v(0, 0, 0, 12, 0, 32'hE, 32'h1004, 0, 0, 1, 32'hBFC0_00FC, 32'h0040_0002));
        vecs.push_back(v(0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000));
        vecs.push_back(v(1, 12, 32'h401, 12, 0, 0, 32'h100, 0, 0, 0, 0, 32'h0040_0000));
        vecs.push_back(v(0, 0, 0, 13, 1, 0, 32'h100, 0, 0, 0, 0, 32'h8000_0010));
        vecs.push_back(v(1, 14, 32'h1234_5678, 13, 1, 32'h8, 32'h2000, 0, 0, 1, VEC, 32'h8000_0410));
        vecs.push_back(v(0, 0, 0, 14, 1, 0, 32'h2004, 0, 0, 0, 0, 32'h0000_2000));
        vecs.push_back(v(0, 0, 0, 13, 1, 0, 32'h2004, 0, 0, 0, 0, 32'h0000_0400));
        vecs.push_back(v(0, 0, 0, 12, 1, 0, 32'h2004, 0, 0, 0, 0, 32'h0040_0403));
        vecs.push_back(v(0, 0, 0, 14, 0, 32'hE, 32'h2008, 0, 0, 1, 32'h0000_2000, 32'h0000_2000));
        vecs.push_back(v(0, 0, 0, 12, 0, 0, 32'h2008, 0, 0, 0, 0, 32'h0040_0401));
        vecs.push_back(v(1, 12, 0, 13, 0, 0, 32'h2008, 0, 0, 0, 0, 32'h0));
        vecs.push_back(v(1, 12, 32'hFFFF_FFFF, 12, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000));
        vecs.push_back(v(0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h0040_FF03));
        vecs.push_back(v(1, 13, 32'hFFFF_FFFF, 12, 0, 0, 0, 0, 0, 0, 0, 32'h0040_FF03));
        vecs.push_back(v(0, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0300));
        vecs.push_back(v(1, 8, 0, 8, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0003));
        vecs.push_back(v(0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0003));
        vecs.push_back(v(1, 20, 32'h5, 20, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(v(1, 12, 0, 20, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        vecs.push_back(v(1, 13, 0, 12, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000));
        vecs.push_back(v(0, 0, 0, 13, 0, 32'h33, 32'h100, 0, 0, 0, 0, 32'h0));
        vecs.push_back(v(0, 0, 0, 13, 0, 32'h1, 32'h100, 0, 0, 0, 0, 32'h0));

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            #1;
            check($sformatf("vec%0d_flush", i), flush_o, vecs[i].exp_flush);
            if (vecs[i].exp_flush)
                check($sformatf("vec%0d_newpc", i), newpc_o, vecs[i].exp_newpc);
            check($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
            @(negedge clk);
        end

        // Timer: Compare=10, Count=0, wait for the interrupt, then clear it
        apply_idle();
        we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd10;
        @(negedge clk);
        waddr_i = 5'd9; wdata_i = 32'd0;
        @(negedge clk);
        we_i = 1'b0; raddr_i = 5'd9;
        waited = 0;
        #1;
        while (!timer_int_o && waited < 60) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("timer_fire", timer_int_o, 1'b1);
        check("timer_count", rdata_o, 32'd10);
        check("timer_latency", (waited >= 15 && waited <= 25), 1'b1);
        @(negedge clk);
        #1;
        check("timer_cause15", cause_o[15], 1'b1);
        we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd0;
        #1;
        check("timer_hold_until_edge", timer_int_o, 1'b1);
        @(negedge clk);
        we_i = 1'b0;
        #1;
        check("timer_cleared", timer_int_o, 1'b0);

        // Reset in the middle of a flushing cycle
        excepttype_i = 32'h8; pc_i = 32'h40;
        #1;
        check("midrst_flush_before", flush_o, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_flush", flush_o, 1'b0);
        check("midrst_status", status_o, 32'h0040_0000);
        check("midrst_cause", cause_o, 32'd0);
        check("midrst_timer", timer_int_o, 1'b0);
        apply_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int r;
            we_i    = ($urandom_range(0, 2) == 0);
            waddr_i = reg_pool[$urandom_range(0, 7)];
            wdata_i = $urandom;
            if (waddr_i == 5'd11 && $urandom_range(0, 1) == 0)
                wdata_i = m_count + $urandom_range(0, 6);
            if (waddr_i == 5'd12 && $urandom_range(0, 1) == 0)
                wdata_i = {$urandom} & 32'hFFFF_FFFD;
            raddr_i = reg_pool[$urandom_range(0, 7)];
            int_i   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            r = $urandom_range(0, 21);
            case (r)
                12: excepttype_i = 32'h1;
                13: excepttype_i = 32'h4;
                14: excepttype_i = 32'h5;
                15: excepttype_i = 32'h8;
                16: excepttype_i = 32'h9;
                17: excepttype_i = 32'hA;
                18: excepttype_i = 32'hC;
                19: excepttype_i = 32'hE;
                20: excepttype_i = 32'h33;
                21: excepttype_i = $urandom;
                default: excepttype_i = 32'h0;
            endcase
            pc_i           = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            in_delayslot_i = $urandom_range(0, 1) == 1;
            bad_vaddr_i    = $urandom;
            #1;
            irq  = m_intreq();
            exc  = irq || m_sync_exc();
            eret = !irq && (excepttype_i == 32'hE);
            check("rnd_flush", flush_o, exc || eret);
            if (exc || eret)
                check("rnd_newpc", newpc_o, exc ? VEC : m_epc);
            check("rnd_rdata", rdata_o, m_read(raddr_i));
            check("rnd_status", status_o, m_status);
            check("rnd_cause", cause_o, m_cause);
            check("rnd_epc", epc_o, m_epc);
            check("rnd_timer", timer_int_o, m_timer);
            model_edge();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
